// File: rtl/secure_scrub_fifo.sv
// Synchronous FIFO that zeroes every entry after reset or a clear request before accepting traffic.
// Optional macro SCRUB_ON_READ_EN: an accepted read also zeroes the popped entry.
module secure_scrub_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] SCRUB = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             idle_op;
  logic             rd_acc;
  logic             wr_acc;

  // A full FIFO can still take a write when the same cycle pops an entry.
  assign idle_op   = (state == IDLE) && !clear;
  assign rd_acc    = idle_op && rd_en && !empty;
  assign wr_acc    = idle_op && wr_en && (!full || rd_acc);
  assign count_nxt = count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCRUB;
      idx      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      busy     <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      case (state)
        SCRUB: begin
          idx <= idx + AW'(1);
          if (idx == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear) begin
            state  <= SCRUB;
            busy   <= 1'b1;
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
          end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
              rd_ptr   <= rd_ptr + AW'(1);
              rd_data  <= mem[rd_ptr];
              rd_valid <= 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
          end
        end
        default: begin
          state <= SCRUB;
          busy  <= 1'b1;
          idx   <= '0;
        end
      endcase
    end
  end

  // Storage carries no reset; the scrub pass is what clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == SCRUB) begin
        mem[idx] <= '0;
      end else begin
`ifdef SCRUB_ON_READ_EN
        if (rd_acc) mem[rd_ptr] <= '0;
`endif
        if (wr_acc) mem[wr_ptr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_secure_scrub_fifo.sv
// Bench for secure_scrub_fifo: queue-based reference model, directed scenarios and random traffic.
module tb_secure_scrub_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             busy;

  secure_scrub_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clear(clear), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] q[$];
  int               scrub_left = 0;
  logic             exp_v = 1'b0;
  logic [WIDTH-1:0] exp_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the FIFO is a queue; a scrub is a countdown of DEPTH cycles during which all requests are ignored.
  task automatic model_edge();
    logic ra, wa;
    exp_v = 1'b0;
    exp_d = '0;
    if (rst) begin
      q.delete();
      scrub_left = DEPTH;
    end else if (scrub_left > 0) begin
      scrub_left--;
    end else if (clear) begin
      q.delete();
      scrub_left = DEPTH;
    end else begin
      ra = rd_en && (q.size() > 0);
      wa = wr_en && ((q.size() < DEPTH) || ra);
      if (ra) begin
        exp_v = 1'b1;
        exp_d = q.pop_front();
      end
      if (wa) q.push_back(wr_data);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic c,
                      input logic [WIDTH-1:0] d);
    rst = r; wr_en = w; rd_en = rd; clear = c; wr_data = d;
    @(posedge clk);
    #1;
    model_edge();
    chk("rd_valid", 32'(rd_valid), 32'(exp_v));
    chk("rd_data", 32'(rd_data), 32'(exp_d));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("busy", 32'(busy), 32'(scrub_left > 0));
  endtask

  task automatic busy_len(input string name);
    int n = 0;
    for (int i = 0; i < 12 && busy; i++) begin
      n++;
      step(0, 0, 0, 0, '0);
    end
    chk(name, 32'(n), 32'd4);
  endtask

  logic [WIDTH-1:0] pat [4];
  logic [WIDTH-1:0] peek;

  initial begin
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

    // Reset then post-reset scrub
    step(1, 0, 0, 0, '0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    busy_len("scrub_len_rst");
    chk("post_scrub_empty", 32'(empty), 32'd1);
    chk("post_scrub_full", 32'(full), 32'd0);

    // Fill, overflow drop, drain
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, pat[i]);
    chk("fill_full", 32'(full), 32'd1);
    step(0, 1, 0, 0, 8'h55);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, '0);
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data", 32'(rd_data), 32'(pat[i]));
    end
    step(0, 0, 0, 0, '0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_idle_data", 32'(rd_data), 32'd0);

    // Simultaneous read+write while full, then wrap
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, pat[i]);
    step(0, 1, 1, 0, 8'h66);
    chk("rw_full_data", 32'(rd_data), 32'h11);
    chk("rw_full_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, '0);
    chk("wrap_last", 32'(rd_data), 32'h66);

    // Clear beats a same-cycle read
    step(0, 1, 0, 0, 8'hA5);
    step(0, 0, 1, 1, '0);
    chk("clear_rd_drop", 32'(rd_valid), 32'd0);
    busy_len("scrub_len_clear");
    step(0, 0, 1, 0, '0);
    chk("after_clear_valid", 32'(rd_valid), 32'd0);
    chk("after_clear_data", 32'(rd_data), 32'd0);

    // Reset during scrub restarts it
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    busy_len("scrub_len_rerst");

    // Retention of a popped entry depends on the build option
    step(0, 1, 0, 0, 8'h5A);
    step(0, 0, 1, 0, '0);
    chk("pop_5a", 32'(rd_data), 32'h5A);
    peek = dut.mem[0];
`ifdef SCRUB_ON_READ_EN
    chk("peek_entry0", 32'(peek), 32'h00);
`else
    chk("peek_entry0", 32'(peek), 32'h5A);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) == 0),
           WIDTH'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/secure_scrub_fifo.md
SECURE_SCRUB_FIFO -- requirements
Module: secure_scrub_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (power of two, >=2); AW = log2(DEPTH).
REQ-003 SHALL have clk  input  1  clock; all logic updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have wr_en  input  1  write request.
REQ-006 SHALL have wr_data  input  WIDTH  write data.
REQ-007 SHALL have rd_en  input  1  read request.
REQ-008 SHALL have clear  input  1  software scrub request; wipes all contents.
REQ-009 SHALL have rd_data  output  WIDTH  registered read data.
REQ-010 SHALL have rd_valid  output  1  rd_data holds a valid pop result this cycle.
REQ-011 SHALL have full  output  1  count == DEPTH.
REQ-012 SHALL have empty  output  1  count == 0.
REQ-013 SHALL have busy  output  1  scrub in progress; wr_en, rd_en and clear are ignored while busy is high.

Function
REQ-014 SHALL implement a two-state FSM, SCRUB and IDLE; rst forces SCRUB with scrub index 0.
REQ-015 In SCRUB, SHALL write zero to entry[index] each cycle and increment index; after entry DEPTH-1 it SHALL go to IDLE, giving exactly DEPTH busy cycles.
REQ-016 In IDLE, clear=1 SHALL enter SCRUB next cycle, zero wr_ptr, rd_ptr and count, and take priority over any same-cycle wr_en or rd_en (both dropped).
REQ-017 In IDLE, wr_en with !full SHALL store wr_data at wr_ptr and advance wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-018 In IDLE, rd_en with !empty SHALL load entry[rd_ptr] into rd_data, pulse rd_valid for one cycle (1-cycle latency), and advance rd_ptr modulo DEPTH.
REQ-019 wr_en while full SHALL be dropped with no state change, unless rd_en is also accepted that cycle.
REQ-020 rd_en while empty SHALL be dropped: rd_valid=0, rd_data=0; there is no write-to-read bypass.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged; when full, both SHALL be accepted.
REQ-022 count SHALL be AW+1 bits and never exceed DEPTH or underflow.
REQ-023 rd_data SHALL be 0 whenever rd_valid is 0, so stale data is never held on the output.
REQ-024 full, empty and busy SHALL be registered and consistent with count and state at each edge.

Reset
REQ-025 On rst: state=SCRUB, index=0, wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, full=0, empty=1, busy=1.
REQ-026 rst asserted mid-scrub or mid-operation SHALL restart the scrub at index 0; a full DEPTH-cycle scrub always follows reset deassertion.
REQ-027 No entry SHALL be readable through rd_data before it has been scrubbed or rewritten since the last rst or clear.

Configuration
REQ-028 Macro SCRUB_ON_READ_EN: when defined, an accepted read SHALL also write zero to entry[rd_ptr] in the same cycle; when undefined, popped entries retain data until overwritten or scrubbed.

Verification
REQ-029 rst 1 cycle, then idle -> busy=1 for exactly 4 cycles, then busy=0, empty=1, full=0.
REQ-030 After scrub, write 0x11,0x22,0x33,0x44 -> full=1; 5th write 0x55 dropped; 4 reads return 0x11..0x44, each rd_valid 1 cycle after rd_en, then empty=1.
REQ-031 Fill 4 entries, then wr_en+rd_en together with 0x66 -> rd_data=0x11, full stays 1, a later read sequence ends with 0x66 (pointer wrap).
REQ-032 Write 0xA5, assert clear with rd_en -> read dropped, busy 4 cycles, then rd_en -> rd_valid=0, rd_data=0x00.
REQ-033 Assert rst at 2nd scrub cycle -> scrub restarts, busy high 4 cycles after rst deasserts.
REQ-034 With SCRUB_ON_READ_EN, write 0x5A, read it, peek memory at entry 0 -> 0x00; without it, entry 0 -> 0x5A.
